// File: rtl/div_subshift_hs.sv
// Sequential restoring divider with valid/ready handshake on both sides.
// One quotient bit per cycle; sign handling is done by magnitude conversion before and after.
module div_subshift_hs #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              sign,
  input  logic [DATA_W-1:0] dividend,
  input  logic [DATA_W-1:0] divisor,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] quotient,
  output logic [DATA_W-1:0] remainder,
  output logic              div_by_zero
);

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;
  state_t state, state_nxt;

  logic [2*DATA_W-1:0] acc;
  logic [DATA_W-1:0]   dvs_mag, dvd_raw;
  logic                q_neg, r_neg, dz;
  logic [CNT_W-1:0]    cnt;

  logic                accept;
  logic [DATA_W-1:0]   dvd_mag_in, dvs_mag_in;
  logic [DATA_W:0]     shifted, diff;
  logic                ge;
  logic [DATA_W-1:0]   new_rem, q_mag, r_mag;

  assign accept     = in_valid && in_ready;
  assign dvd_mag_in = (sign && dividend[DATA_W-1]) ? -dividend : dividend;
  assign dvs_mag_in = (sign && divisor[DATA_W-1])  ? -divisor  : divisor;

  // Partial remainder gets one extra bit so the compare never loses a carry.
  assign shifted = {acc[2*DATA_W-1:DATA_W], acc[DATA_W-1]};
  assign diff    = shifted - {1'b0, dvs_mag};
  assign ge      = shifted >= {1'b0, dvs_mag};
  assign new_rem = ge ? diff[DATA_W-1:0] : shifted[DATA_W-1:0];
  assign q_mag   = acc[DATA_W-1:0];
  assign r_mag   = acc[2*DATA_W-1:DATA_W];

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = RUN;
      RUN:  if (cnt == LAST) state_nxt = FIX;
      FIX:  state_nxt = DONE;
      DONE: if (out_ready) state_nxt = in_valid ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: in_ready = 1'b1;
      DONE: begin
        in_ready  = out_ready;
        out_valid = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc         <= '0;
      dvs_mag     <= '0;
      dvd_raw     <= '0;
      q_neg       <= 1'b0;
      r_neg       <= 1'b0;
      dz          <= 1'b0;
      cnt         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else if (accept) begin
      acc     <= {{DATA_W{1'b0}}, dvd_mag_in};
      dvs_mag <= dvs_mag_in;
      dvd_raw <= dividend;
      q_neg   <= sign && (dividend[DATA_W-1] ^ divisor[DATA_W-1]);
      r_neg   <= sign && dividend[DATA_W-1];
      dz      <= (divisor == '0);
      cnt     <= '0;
    end else if (state == RUN) begin
      acc <= {new_rem, acc[DATA_W-2:0], ge};
      cnt <= cnt + CNT_W'(1);
    end else if (state == FIX) begin
      // Zero divisor overrides whatever the shift-subtract loop produced.
      quotient    <= dz ? '1      : (q_neg ? -q_mag : q_mag);
      remainder   <= dz ? dvd_raw : (r_neg ? -r_mag : r_mag);
      div_by_zero <= dz;
    end
  end

endmodule
